// File: rtl/ram_1h_arbiter.sv
// Single-port RAM arbiter: power-up clear, then video-priority sharing
// with a CPU port protected against starvation.
module ram_1h_arbiter #(
  parameter int unsigned addr_width_g = 11,
  parameter int unsigned data_width_g = 8,
  parameter logic [data_width_g-1:0] clear_value_g = '0,
  parameter int unsigned starve_limit_g = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [addr_width_g-1:0] cpu_addr_i,
  input  logic [data_width_g-1:0] cpu_din_i,
  output logic [data_width_g-1:0] cpu_dout_o,
  output logic                    cpu_ack_o,
  input  logic                    vid_req_i,
  input  logic [addr_width_g-1:0] vid_addr_i,
  output logic [data_width_g-1:0] vid_dout_o,
  output logic                    vid_valid_o,
  output logic                    ram_clken_o,
  output logic                    ram_wren_o,
  output logic [addr_width_g-1:0] ram_address_o,
  output logic [data_width_g-1:0] ram_data_o,
  input  logic [data_width_g-1:0] ram_q_i,
  output logic                    clear_done_o
);

  localparam int unsigned SW = $clog2(starve_limit_g + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(starve_limit_g);
  localparam logic [addr_width_g-1:0] LAST_ADDR = '1;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_e;

  state_e state_q, state_d;

  logic [addr_width_g-1:0] clr_cnt_q, clr_cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic out_q, out_d;

  logic p1_cpu_q, p1_we_q, p1_vid_q;
  logic cpu_ack_q, vid_valid_q;
  logic [data_width_g-1:0] cpu_dout_q, vid_dout_q;

  logic run;
  logic clearing;
  logic cpu_elig;
  logic starved;
  logic cpu_gnt;
  logic vid_gnt;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  assign run      = (state_q == S_RUN);
  assign clearing = (state_q == S_CLEAR) && !reset_i;
  assign cpu_elig = cpu_req_i && !out_q;
  assign starved  = (starve_q == STARVE_MAX);
  assign cpu_gnt  = run && cpu_elig && (!vid_req_i || starved);
  assign vid_gnt  = run && vid_req_i && !cpu_gnt;

  // Output logic: RAM port follows the current-cycle grant
  always_comb begin
    ram_clken_o   = 1'b0;
    ram_wren_o    = 1'b0;
    ram_address_o = '0;
    ram_data_o    = '0;
    unique case (1'b1)
      clearing: begin
        ram_clken_o   = 1'b1;
        ram_wren_o    = 1'b1;
        ram_address_o = clr_cnt_q;
        ram_data_o    = clear_value_g;
      end
      cpu_gnt: begin
        ram_clken_o   = 1'b1;
        ram_wren_o    = cpu_we_i;
        ram_address_o = cpu_addr_i;
        ram_data_o    = cpu_din_i;
      end
      vid_gnt: begin
        ram_clken_o   = 1'b1;
        ram_address_o = vid_addr_i;
      end
      default: begin
        ram_clken_o   = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (cpu_gnt) begin
      out_d = 1'b1;
    end else if (cpu_ack_q) begin
      out_d = 1'b0;
    end
  end

  // Counts eligible CPU cycles lost to video, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (cpu_gnt) begin
      starve_d = '0;
    end else if (cpu_elig && vid_gnt && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      out_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      out_q    <= out_d;
      starve_q <= starve_d;
    end
  end

  // Grant in T, RAM data in T+1, result presented in T+2
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      p1_cpu_q    <= 1'b0;
      p1_we_q     <= 1'b0;
      p1_vid_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      vid_dout_q  <= '0;
    end else begin
      p1_cpu_q    <= cpu_gnt;
      p1_we_q     <= cpu_gnt && cpu_we_i;
      p1_vid_q    <= vid_gnt;
      cpu_ack_q   <= p1_cpu_q;
      vid_valid_q <= p1_vid_q;
      if (p1_cpu_q && !p1_we_q) begin
        cpu_dout_q <= ram_q_i;
      end
      if (p1_vid_q) begin
        vid_dout_q <= ram_q_i;
      end
    end
  end

  assign cpu_ack_o    = cpu_ack_q;
  assign cpu_dout_o   = cpu_dout_q;
  assign vid_valid_o  = vid_valid_q;
  assign vid_dout_o   = vid_dout_q;
  assign clear_done_o = run;

endmodule
